// File: rtl/seg7_disp_sched.sv
// seg7_disp_sched
//   Time-shares one 8-digit seven-segment driver among NSRC requesters.
//   Grants are round-robin with a guaranteed minimum hold of HOLD_CYC
//   cycles. After the hold expires the owner keeps the display until
//   another source asks for it or it stops requesting. A manual lock
//   pins the source chosen by sel_sw to the display.
//
// Ports:
//   clk        system clock
//   rstn       asynchronous active-low reset
//   req        per-source level request
//   src_data   source k data word in bits [64k+63:64k]
//   src_mode   source k display mode (0 = hex from [31:0], 1 = raw segments)
//   lock       manual override enable
//   sel_sw     source forced while lock is high
//   gnt        one-hot grant (or zero), registered
//   cur_src    index of the current or last grantee, registered
//   disp_data  driver i_data, registered (all ones = segments off)
//   disp_mode  driver disp_mode, registered
//   busy       high while a source is granted
//   pend       (SEG7_SCHED_PEND_EN only) registered req & ~gnt
//   starve     (SEG7_SCHED_PEND_EN only) a source has waited more than
//              2*NSRC*HOLD_CYC cycles without a grant
//
// Build option: define SEG7_SCHED_PEND_EN to add pend/starve and the
// per-source wait counters behind them.
module seg7_disp_sched #(
  parameter int NSRC     = 4,
  parameter int SEL_W    = 2,
  parameter int HOLD_CYC = 50000000,
  parameter int HOLD_W   = 26
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NSRC-1:0]      req,
  input  logic [64*NSRC-1:0]   src_data,
  input  logic [NSRC-1:0]      src_mode,
  input  logic                 lock,
  input  logic [SEL_W-1:0]     sel_sw,
  output logic [NSRC-1:0]      gnt,
  output logic [SEL_W-1:0]     cur_src,
  output logic [63:0]          disp_data,
  output logic                 disp_mode,
  output logic                 busy
`ifdef SEG7_SCHED_PEND_EN
  ,
  output logic [NSRC-1:0]      pend,
  output logic                 starve
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_SHARE, S_LOCK} state_t;

  localparam logic [63:0]       BLANK     = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);

  state_t              state_reg;
  logic [HOLD_W-1:0]   hold_cnt_reg;
  logic [SEL_W-1:0]    rr_ptr_reg;
  logic [SEL_W-1:0]    cur_src_reg;
  logic [NSRC-1:0]     gnt_reg;
  logic [63:0]         disp_data_reg;
  logic                disp_mode_reg;
  logic                busy_reg;

  logic [63:0]         src_arr [NSRC];
  logic [NSRC-1:0]     share_req;
  logic [SEL_W-1:0]    idle_pick;
  logic [SEL_W-1:0]    share_pick;
  logic                grant_go;
  logic [SEL_W-1:0]    grant_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      assign src_arr[gi] = src_data[64*gi +: 64];
    end
  endgenerate

  // Index lookups go through compare loops so that an out-of-range index
  // (sel_sw >= NSRC) naturally yields the blank/idle value.
  function automatic logic [63:0] data_of(input logic [SEL_W-1:0] k);
    logic [63:0] d;
    d = BLANK;
    for (int i = 0; i < NSRC; i++)
      if (k == SEL_W'(i)) d = src_arr[i];
    return d;
  endfunction

  function automatic logic mode_of(input logic [SEL_W-1:0] k);
    logic m;
    m = 1'b1;
    for (int i = 0; i < NSRC; i++)
      if (k == SEL_W'(i)) m = src_mode[i];
    return m;
  endfunction

  function automatic logic req_of(input logic [SEL_W-1:0] k);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NSRC; i++)
      if (k == SEL_W'(i)) r = req[i];
    return r;
  endfunction

  function automatic logic [NSRC-1:0] onehot(input logic [SEL_W-1:0] k);
    logic [NSRC-1:0] o;
    o = '0;
    for (int i = 0; i < NSRC; i++)
      o[i] = (k == SEL_W'(i));
    return o;
  endfunction

  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] k);
    int s;
    s = (int'(k) + 1) % NSRC;
    return SEL_W'(s);
  endfunction

  // Rotate the request vector so bit 0 is the rr pointer, take the first
  // set bit, then map back to an absolute index.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NSRC-1:0] r,
                                               input logic [SEL_W-1:0] ptr);
    logic [2*NSRC-1:0] dbl;
    logic [NSRC-1:0]   rot;
    logic              found;
    int                s;
    dbl   = {r, r};
    rot   = NSRC'(dbl >> ptr);
    found = 1'b0;
    s     = int'(ptr);
    for (int i = 0; i < NSRC; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        s     = int'(ptr) + i;
        if (s >= NSRC) s = s - NSRC;
      end
    end
    return SEL_W'(s);
  endfunction

  assign share_req  = req & ~gnt_reg;
  assign idle_pick  = rr_pick(req, rr_ptr_reg);
  assign share_pick = rr_pick(share_req, rr_ptr_reg);

  // A new grant is issued from IDLE on any request, or from SHARE when a
  // source other than the current owner is asking.
  always_comb begin
    grant_go  = 1'b0;
    grant_idx = idle_pick;
    if (state_reg == S_IDLE) begin
      grant_go = |req;
    end else if (state_reg == S_SHARE) begin
      grant_go  = |share_req;
      grant_idx = share_pick;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= S_IDLE;
      hold_cnt_reg  <= '0;
      rr_ptr_reg    <= '0;
      cur_src_reg   <= '0;
      gnt_reg       <= '0;
      disp_data_reg <= BLANK;
      disp_mode_reg <= 1'b1;
      busy_reg      <= 1'b0;
    end else if (lock) begin
      // Locked: follow sel_sw live, ignore req and the hold counter.
      state_reg     <= S_LOCK;
      cur_src_reg   <= sel_sw;
      gnt_reg       <= onehot(sel_sw);
      busy_reg      <= (int'(sel_sw) < NSRC);
      disp_data_reg <= data_of(sel_sw);
      disp_mode_reg <= mode_of(sel_sw);
    end else if (state_reg == S_LOCK) begin
      // Release: one blank cycle, arbitration resumes after the pinned source.
      state_reg     <= S_IDLE;
      rr_ptr_reg    <= next_ptr(sel_sw);
      gnt_reg       <= '0;
      busy_reg      <= 1'b0;
      disp_data_reg <= BLANK;
      disp_mode_reg <= 1'b1;
    end else if (grant_go) begin
      state_reg     <= S_HOLD;
      hold_cnt_reg  <= HOLD_LOAD;
      rr_ptr_reg    <= next_ptr(grant_idx);
      cur_src_reg   <= grant_idx;
      gnt_reg       <= onehot(grant_idx);
      busy_reg      <= 1'b1;
      disp_data_reg <= data_of(grant_idx);
      disp_mode_reg <= mode_of(grant_idx);
    end else begin
      case (state_reg)
        S_HOLD: begin
          if (hold_cnt_reg == '0) state_reg <= S_SHARE;
          else                    hold_cnt_reg <= hold_cnt_reg - HOLD_W'(1);
          // Owner dropped its request: keep the grant, freeze the data.
          if (req_of(cur_src_reg)) begin
            disp_data_reg <= data_of(cur_src_reg);
            disp_mode_reg <= mode_of(cur_src_reg);
          end
        end
        S_SHARE: begin
          if (req_of(cur_src_reg)) begin
            disp_data_reg <= data_of(cur_src_reg);
            disp_mode_reg <= mode_of(cur_src_reg);
          end else begin
            state_reg     <= S_IDLE;
            gnt_reg       <= '0;
            busy_reg      <= 1'b0;
            disp_data_reg <= BLANK;
            disp_mode_reg <= 1'b1;
          end
        end
        default: begin
          gnt_reg       <= '0;
          busy_reg      <= 1'b0;
          disp_data_reg <= BLANK;
          disp_mode_reg <= 1'b1;
        end
      endcase
    end
  end

  assign gnt       = gnt_reg;
  assign cur_src   = cur_src_reg;
  assign disp_data = disp_data_reg;
  assign disp_mode = disp_mode_reg;
  assign busy      = busy_reg;

`ifdef SEG7_SCHED_PEND_EN
  // Wide enough for 2*NSRC*HOLD_CYC with NSRC <= 8.
  localparam int    WAIT_W     = HOLD_W + 5;
  localparam longint STARVE_LIM = 2 * longint'(NSRC) * longint'(HOLD_CYC);

  logic [NSRC-1:0] pend_reg;
  logic [NSRC-1:0] starve_flags;
  logic            starve_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_reg   <= '0;
      starve_reg <= 1'b0;
    end else begin
      pend_reg   <= req & ~gnt_reg;
      starve_reg <= |starve_flags;
    end
  end

  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_wait
      logic [WAIT_W-1:0] wait_cnt_reg;
      logic              flag_reg;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          wait_cnt_reg <= '0;
          flag_reg     <= 1'b0;
        end else if (gnt_reg[gi]) begin
          wait_cnt_reg <= '0;
          flag_reg     <= 1'b0;
        end else if (pend_reg[gi]) begin
          if (wait_cnt_reg != '1) wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
          if (wait_cnt_reg > WAIT_W'(STARVE_LIM)) flag_reg <= 1'b1;
        end else begin
          // Only a continuous wait counts; the flag itself clears on grant.
          wait_cnt_reg <= '0;
        end
      end
      assign starve_flags[gi] = flag_reg;
    end
  endgenerate

  assign pend   = pend_reg;
  assign starve = starve_reg;
`endif

endmodule

// File: doc/seg7_disp_sched.md
Name: seg7_disp_sched

Overview:
- Time-shares the single 8-digit seven-segment driver among NSRC display requesters, such as CPU debug and switch echo.
- Each requester presents a 64-bit data word and a display-mode bit. The block grants one requester at a time using round-robin order and a guaranteed minimum hold time.
- It drives the driver's i_data/disp_mode inputs from registers.
- A manual lock lets the board switches pin one source to the display.

Parameters:
- NSRC, 4: number of requesters. Must be 2..8.
- SEL_W, 2: width of sel_sw and cur_src. Must satisfy 2^SEL_W >= NSRC.
- HOLD_CYC, 50000000: minimum number of clk cycles a grant is held. Must be >= 2.
- HOLD_W, 26: hold counter width. Must satisfy 2^HOLD_W > HOLD_CYC.

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low
- req  in  NSRC  per-source display request, level-sensitive
- src_data  in  64*NSRC  source k data in bits [64k+63:64k]
- src_mode  in  NSRC  source k disp_mode: 0 = hex digits from bits [31:0], 1 = raw segments
- lock  in  1  manual override enable
- sel_sw  in  SEL_W  source index forced while lock=1
- gnt  out  NSRC  one-hot grant (or all zero), registered
- cur_src  out  SEL_W  index of the current/last grantee, registered
- disp_data  out  64  to driver i_data, registered
- disp_mode  out  1  to driver disp_mode, registered
- busy  out  1  1 when any source is granted

Behaviour:
- Reset values: gnt=0, cur_src=0, busy=0, disp_mode=1, disp_data=64'hFFFF_FFFF_FFFF_FFFF (all segments off), rr_ptr=0, state=IDLE, hold_cnt=0.
- Round-robin pick: the first k with req[k]=1, searching from (rr_ptr) upward with wrap-around at NSRC-1 -> 0.
- On each grant to source k, rr_ptr <= (k+1) mod NSRC.
- State IDLE:
  - Outputs are blank (reset values for disp_data, disp_mode, gnt, busy).
  - If any req bit is high in cycle N: gnt, cur_src and busy update at edge N+1, the state goes to HOLD, and hold_cnt is loaded with HOLD_CYC-1.
  - disp_data/disp_mode show the grantee's values from edge N+1.
- State HOLD:
  - hold_cnt decrements by 1 each cycle.
  - While req[cur_src]=1, disp_data/disp_mode track the source live, with 1-cycle registered latency.
  - If req[cur_src] drops, disp_data/disp_mode freeze at the last captured value and gnt stays asserted.
  - Requests from other sources are ignored.
  - When hold_cnt=0, the state goes to SHARE on the next edge.
- State SHARE:
  - If any other source requests, re-arbitrate from rr_ptr and switch directly to the new grantee: gnt changes on the next edge with no blank cycle, and the state goes to HOLD with the counter reloaded.
  - Else, if req[cur_src]=1, stay in SHARE with live data tracking.
  - Else go to IDLE: outputs blank on the next edge and gnt=0.
- Simultaneous requests: the round-robin pick resolves them. Exactly one gnt bit is ever set.
- Lock, from any state:
  - lock=1 sampled at edge N: at edge N+1, gnt = onehot(sel_sw), cur_src = sel_sw, busy=1, and data/mode track src_data[sel_sw] live regardless of req.
  - hold_cnt is not used while locked.
  - A change of sel_sw while locked takes effect on the next edge.
  - sel_sw >= NSRC: gnt=0, busy=0, outputs blank.
- Lock release: lock 1 -> 0 goes to IDLE on the next edge (blank for 1 cycle) with rr_ptr = (sel_sw+1) mod NSRC, then normal arbitration resumes.
- Reset asserted mid-grant: all outputs return to reset values immediately, asynchronously.

Optional Feature:
- Macro: SEG7_SCHED_PEND_EN.
- Defined: adds output port pend [NSRC-1:0] = registered (req & ~gnt), reset 0. It shows which sources are waiting, for LED display.
- Also defined: adds output starve (1 bit, registered, reset 0), set when any source has pended for more than 2*NSRC*HOLD_CYC cycles, cleared when that source is granted. This needs one wait counter per source.
- Undefined: neither port exists and no wait counters are built. All other behaviour is identical.

Test Plan:
- Reset, then release with req=0 -> disp_data=64'hFFFF_FFFF_FFFF_FFFF, disp_mode=1, gnt=0, busy=0 held for 20 cycles.
- HOLD_CYC=4. req=4'b0001, src_data[0]=64'h1234_5678, src_mode[0]=0 -> 1 cycle later gnt=0001 and disp_data=64'h1234_5678. Change the data to 64'hABCD -> visible 1 cycle later.
- HOLD_CYC=4. req=4'b1111 held -> grant order 0,1,2,3,0 with each grant lasting exactly 5 cycles (4 HOLD + 1 SHARE), and no all-zero gnt cycle between grants.
- req[1] pulses for 1 cycle at grant -> gnt=0010 is held for the full HOLD period with data frozen, then IDLE and blank.
- lock=1, sel_sw=2, req=0, src_data[2]=64'h55 -> next edge gnt=0100, disp_data=64'h55. Set sel_sw=3 -> gnt=1000 on the next edge. Drop lock -> 1 blank cycle, rr_ptr=0.
- With SEG7_SCHED_PEND_EN: req=0011, source 0 granted -> pend=0010 until source 1 is granted, then pend=0001.
